// File: rtl/pong_game_controller.sv
// pong_game_controller
//   Top-level sequencing FSM for the pong display. It tracks the game phase,
//   the balls in reserve, a two-digit BCD score and an inter-phase delay
//   timer. It feeds the text generator and freezes the graphics between
//   phases.
//
// Ports
//   clk        system/pixel clock, rising edge
//   reset      asynchronous, active-high reset
//   btn[1:0]   debounced paddle buttons; pressed when nonzero
//   refr_tick  one-cycle pulse per video frame
//   hit        one-cycle pulse when the ball hits the paddle
//   miss       one-cycle pulse when the ball passes the paddle
//   ball[1:0]  balls remaining in reserve
//   dig1[3:0]  score tens digit (BCD)
//   dig0[3:0]  score units digit (BCD)
//   text_en    region enables {score, logo, rule, over}
//   gra_still  1 freezes the ball/paddle graphics
//   timer_up   delay timer is at 0
module pong_game_controller #(
  parameter int BALLS      = 3,
  parameter int TIMER_LOAD = 127
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] btn,
  input  logic       refr_tick,
  input  logic       hit,
  input  logic       miss,
  output logic [1:0] ball,
  output logic [3:0] dig1,
  output logic [3:0] dig0,
  output logic [3:0] text_en,
  output logic       gra_still,
  output logic       timer_up
);

  typedef enum logic [1:0] {
    NEWGAME = 2'd0,
    PLAY    = 2'd1,
    NEWBALL = 2'd2,
    OVER    = 2'd3
  } state_t;

  localparam logic [1:0] BALLS_INIT = 2'(BALLS);
  localparam logic [6:0] TIMER_INIT = 7'(TIMER_LOAD);

  state_t     state;
  logic [6:0] timer;
  logic       pressed;
  logic       score_inc;
  logic       timer_load;

  assign pressed    = (btn != 2'b00);
  assign score_inc  = (state == PLAY) && hit;
  assign timer_load = (state == PLAY) && miss;
  assign timer_up   = (timer == '0);

  // Phase sequencing and ball reserve
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= NEWGAME;
      ball  <= BALLS_INIT;
    end else begin
      unique case (state)
        NEWGAME: begin
          if (pressed) begin
            state <= PLAY;
            ball  <= BALLS_INIT - 2'd1;
          end else begin
            ball  <= BALLS_INIT;
          end
        end
        PLAY: begin
          if (miss) begin
            if (ball == '0) begin
              state <= OVER;
            end else begin
              state <= NEWBALL;
              ball  <= ball - 2'd1;
            end
          end
        end
        NEWBALL: begin
          if (timer_up && pressed) state <= PLAY;
        end
        OVER: begin
          if (timer_up) state <= NEWGAME;
        end
        default: state <= NEWGAME;
      endcase
    end
  end

  // Two-digit BCD score, wrapping 99 -> 00
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dig1 <= '0;
      dig0 <= '0;
    end else if (state == NEWGAME) begin
      dig1 <= '0;
      dig0 <= '0;
    end else if (score_inc) begin
      if (dig0 == 4'd9) begin
        dig0 <= '0;
        dig1 <= (dig1 == 4'd9) ? 4'd0 : dig1 + 4'd1;
      end else begin
        dig0 <= dig0 + 4'd1;
      end
    end
  end

  // Delay timer: a load beats a coincident refr_tick decrement
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer <= '0;
    end else if (timer_load) begin
      timer <= TIMER_INIT;
    end else if (refr_tick && (timer != '0)) begin
      timer <= timer - 7'd1;
    end
  end

  // Moore decode from the state register
  always_comb begin
    text_en   = 4'b1110;
    gra_still = 1'b1;
    unique case (state)
      NEWGAME: begin text_en = 4'b1110; gra_still = 1'b1; end
      PLAY:    begin text_en = 4'b1100; gra_still = 1'b0; end
      NEWBALL: begin text_en = 4'b1100; gra_still = 1'b1; end
      OVER:    begin text_en = 4'b1101; gra_still = 1'b1; end
      default: begin text_en = 4'b1110; gra_still = 1'b1; end
    endcase
  end

endmodule

// File: tb/tb_pong_game_controller.sv
// tb_pong_game_controller
//   Directed bench for pong_game_controller. Expected output words are pushed
//   to a scoreboard queue as stimulus is applied and popped when sampled.
module tb_pong_game_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] btn;
  logic       refr_tick;
  logic       hit;
  logic       miss;
  logic [1:0] ball;
  logic [3:0] dig1;
  logic [3:0] dig0;
  logic [3:0] text_en;
  logic       gra_still;
  logic       timer_up;

  always #5 clk = ~clk;

  pong_game_controller #(.BALLS(3), .TIMER_LOAD(127)) dut (
    .clk       (clk),
    .reset     (reset),
    .btn       (btn),
    .refr_tick (refr_tick),
    .hit       (hit),
    .miss      (miss),
    .ball      (ball),
    .dig1      (dig1),
    .dig0      (dig0),
    .text_en   (text_en),
    .gra_still (gra_still),
    .timer_up  (timer_up)
  );

  localparam logic [3:0] TE_NG = 4'b1110;
  localparam logic [3:0] TE_PL = 4'b1100;
  localparam logic [3:0] TE_OV = 4'b1101;

  typedef struct {
    string       tag;
    logic [15:0] v;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Output word: {ball, dig1, dig0, text_en, gra_still, timer_up}
  function automatic logic [15:0] mk(int b, int s, logic [3:0] te, logic still, logic tup);
    return {2'(b), 4'(s / 10), 4'(s % 10), te, still, tup};
  endfunction

  task automatic expect_out(string tag, logic [15:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t        e;
    logic [15:0] obs;
    obs = {ball, dig1, dig0, text_en, gra_still, timer_up};
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%h expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.v) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset = 1'b0; btn = 2'b00; refr_tick = 1'b0; hit = 1'b0; miss = 1'b0;
    #1 reset = 1'b1;
    #1;
    expect_out("reset_async", mk(3, 0, TE_NG, 1'b1, 1'b1));
    check_out();
    step(2);
    reset = 1'b0;
    step(10);
    expect_out("idle_newgame", mk(3, 0, TE_NG, 1'b1, 1'b1));
    check_out();

    btn = 2'b01; step(); btn = 2'b00;
    expect_out("start_play", mk(2, 0, TE_PL, 1'b0, 1'b1));
    check_out();

    hit = 1'b1; step(12); hit = 1'b0;
    expect_out("score_12", mk(2, 12, TE_PL, 1'b0, 1'b1));
    check_out();

    hit = 1'b1; step(87); hit = 1'b0;
    expect_out("score_99", mk(2, 99, TE_PL, 1'b0, 1'b1));
    check_out();

    hit = 1'b1; step(); hit = 1'b0;
    expect_out("score_wrap", mk(2, 0, TE_PL, 1'b0, 1'b1));
    check_out();

    hit = 1'b1; step(5); hit = 1'b0;
    expect_out("score_05", mk(2, 5, TE_PL, 1'b0, 1'b1));
    check_out();

    // hit, miss and refr_tick together: score moves, miss taken, load wins
    hit = 1'b1; miss = 1'b1; refr_tick = 1'b1; step();
    hit = 1'b0; miss = 1'b0; refr_tick = 1'b0;
    expect_out("hit_miss_tick", mk(1, 6, TE_PL, 1'b1, 1'b0));
    check_out();

    miss = 1'b1; step(); miss = 1'b0;
    expect_out("miss_ignored_newball", mk(1, 6, TE_PL, 1'b1, 1'b0));
    check_out();

    btn = 2'b10; hit = 1'b1; refr_tick = 1'b1; step(126);
    hit = 1'b0; refr_tick = 1'b0;
    expect_out("newball_126_ticks", mk(1, 6, TE_PL, 1'b1, 1'b0));
    check_out();

    refr_tick = 1'b1; step(); refr_tick = 1'b0;
    expect_out("newball_127_ticks", mk(1, 6, TE_PL, 1'b1, 1'b1));
    check_out();

    step();
    btn = 2'b00;
    expect_out("newball_exit", mk(1, 6, TE_PL, 1'b0, 1'b1));
    check_out();

    miss = 1'b1; step(); miss = 1'b0;
    expect_out("miss_2", mk(0, 6, TE_PL, 1'b1, 1'b0));
    check_out();

    refr_tick = 1'b1;
    for (int i = 0; i < 300 && !timer_up; i++) step();
    refr_tick = 1'b0;
    expect_out("timer_wait", mk(0, 6, TE_PL, 1'b1, 1'b1));
    check_out();

    btn = 2'b01; step(); btn = 2'b00;
    expect_out("resume_play", mk(0, 6, TE_PL, 1'b0, 1'b1));
    check_out();

    miss = 1'b1; step(); miss = 1'b0;
    expect_out("game_over", mk(0, 6, TE_OV, 1'b1, 1'b0));
    check_out();

    refr_tick = 1'b1; step(126); refr_tick = 1'b0;
    expect_out("over_126_ticks", mk(0, 6, TE_OV, 1'b1, 1'b0));
    check_out();

    refr_tick = 1'b1; step(); refr_tick = 1'b0;
    expect_out("over_127_ticks", mk(0, 6, TE_OV, 1'b1, 1'b1));
    check_out();

    step(2);
    expect_out("back_to_newgame", mk(3, 0, TE_NG, 1'b1, 1'b1));
    check_out();

    btn = 2'b01; step(); btn = 2'b00;
    hit = 1'b1; step(42); hit = 1'b0;
    expect_out("score_42", mk(2, 42, TE_PL, 1'b0, 1'b1));
    check_out();

    // Reset between edges must take effect without waiting for a clock
    #2 reset = 1'b1;
    #1;
    expect_out("reset_mid_game", mk(3, 0, TE_NG, 1'b1, 1'b1));
    check_out();
    step();
    reset = 1'b0;
    step(2);

    if (sb.size() != 0) begin
      errors++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pong_game_controller.md
# pong_game_controller

Top-level sequencing FSM for the pong display. It tracks game phase, remaining balls, a two-digit BCD score and an inter-phase delay timer. It drives the `ball`/`dig0`/`dig1` inputs of `pong_text_generator`, plus per-region text enables and a freeze signal for the graphics generator. It sits between the button/collision logic and the text/graph pixel generators, in the `clk` domain of the VGA pipeline.

## Interface
Parameters:
- `BALLS`, 3, balls per game (1..3).
- `TIMER_LOAD`, 127, delay length in `refr_tick` pulses (1..127; ≈2.1 s at 60 Hz).

Ports:
- `clk` in 1: system/pixel clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `btn` in 2: debounced paddle buttons, level-sensitive; "pressed" means `btn != 0`.
- `refr_tick` in 1: one-cycle pulse per video frame.
- `hit` in 1: one-cycle pulse when the ball hits the paddle.
- `miss` in 1: one-cycle pulse when the ball passes the paddle.
- `ball` out 2: balls remaining in reserve (registered).
- `dig1` out 4: score tens digit, BCD (registered).
- `dig0` out 4: score units digit, BCD (registered).
- `text_en` out 4: region enables {score, logo, rule, over}; AND these with the text generator's `text_on`.
- `gra_still` out 1: 1 freezes the ball/paddle graphics.
- `timer_up` out 1: delay timer is at 0.

## Operation
FSM has four states, 2-bit encoding: NEWGAME=0, PLAY=1, NEWBALL=2, OVER=3.

- NEWGAME:
  - `ball` is held at BALLS and the score is cleared each cycle; `gra_still`=1; `text_en`=1110.
  - Button pressed → PLAY, with `ball` ← BALLS−1.
- PLAY:
  - `gra_still`=0; `text_en`=1100.
  - `hit` increments the score.
  - `miss` with `ball`==0 → OVER; the timer is loaded.
  - `miss` with `ball`>0 → NEWBALL; `ball` ← `ball`−1 and the timer is loaded.
- NEWBALL:
  - `gra_still`=1; `text_en`=1100.
  - Moves to PLAY only when `timer_up` and the button is pressed in the same cycle. `ball` is unchanged.
- OVER:
  - `gra_still`=1; `text_en`=1101.
  - `timer_up` → NEWGAME.

Score counter:
- BCD, range 00..99, incremented only in PLAY on `hit`.
- `dig0` 9→0 carries into `dig1`.
- 99 + hit wraps to 00.
- It is cleared only in NEWGAME and by reset. OVER keeps the final score visible.

Delay timer:
- 7-bit down counter.
- Loading it sets the count to TIMER_LOAD; a load has priority over decrement.
- Otherwise it decrements on `refr_tick` while nonzero and stops at 0.
- `timer_up` = (count == 0).

Simultaneous events:
- `hit` and `miss` together in PLAY: both take effect. The score increments and the miss transition occurs.
- `hit`/`miss` outside PLAY are ignored.
- `refr_tick` in the same cycle as a timer load: the load wins.
- Button held through OVER→NEWGAME: PLAY is entered one cycle after NEWGAME. This is accepted behaviour; no edge detection is done.

Reset:
- Asynchronous.
- Values: state=NEWGAME, `ball`=BALLS, `dig1`=`dig0`=0, timer=0 (`timer_up`=1), `gra_still`=1, `text_en`=1110.
- Reset asserted mid-game aborts immediately to these values.

## Timing
- Inputs are sampled on the rising edge of `clk`. The state, `ball`, digits and timer update on that same edge, so outputs reflect an input event one cycle after it is presented.
- `text_en` and `gra_still` are Moore outputs decoded from the state register, with no added latency beyond the state update.
- The timer reaches 0 exactly TIMER_LOAD `refr_tick` pulses after the load edge. NEWBALL/OVER can exit on the cycle `timer_up` first reads 1.
- There are no combinational paths from inputs to outputs.
- Games played per NEWGAME→OVER pass: exactly BALLS misses.

## Test plan
- Reset, then release with `btn`=0 for 10 cycles → state NEWGAME, `ball`=3, digits 00, `text_en`=1110, `gra_still`=1, `timer_up`=1.
- `btn`=01 for 1 cycle, then 12 `hit` pulses → PLAY, `ball`=2, `dig1`/`dig0`=1/2, `text_en`=1100, `gra_still`=0.
- Force score 99 (99 hits), then 1 more hit → 00. Also: `hit`+`miss` in the same cycle at score 05 with `ball`=2 → score 06, NEWBALL, `ball`=1, timer=127.
- In NEWBALL, hold `btn`=10 and issue 126 `refr_tick`s → stays in NEWBALL. On the 127th tick `timer_up`=1 → PLAY on the next edge.
- Three misses, each followed by a timer wait and press → OVER after the 3rd miss with `ball`=0 and `text_en`=1101. After 127 ticks → NEWGAME, score cleared, `ball`=3.
- Assert `reset` asynchronously between clock edges while in PLAY with score 42 → outputs reach their reset values before the next edge. Also: `refr_tick` coinciding with a miss → timer=127, not 126.
